// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: segment bit order, the active-low code set
// for hex digits 0..F, the blank pattern, and the capture FSM state type.
package seg7_pkg;

  // Segment bit positions inside a 7-bit pattern (bit 0 = a ... bit 6 = g).
  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  // Active-low codes, written g..a (MSB first). A 0 bit lights the segment.
  localparam logic [6:0] SEG_HEX_0 = 7'b1000000;
  localparam logic [6:0] SEG_HEX_1 = 7'b1111001;
  localparam logic [6:0] SEG_HEX_2 = 7'b0100100;
  localparam logic [6:0] SEG_HEX_3 = 7'b0110000;
  localparam logic [6:0] SEG_HEX_4 = 7'b0011001;
  localparam logic [6:0] SEG_HEX_5 = 7'b0010010;
  localparam logic [6:0] SEG_HEX_6 = 7'b0000010;
  localparam logic [6:0] SEG_HEX_7 = 7'b1111000;
  localparam logic [6:0] SEG_HEX_8 = 7'b0000000;
  localparam logic [6:0] SEG_HEX_9 = 7'b0011000;
  localparam logic [6:0] SEG_HEX_A = 7'b0001000;
  localparam logic [6:0] SEG_HEX_B = 7'b0000011;
  localparam logic [6:0] SEG_HEX_C = 7'b1000110;
  localparam logic [6:0] SEG_HEX_D = 7'b0100001;
  localparam logic [6:0] SEG_HEX_E = 7'b0000110;
  localparam logic [6:0] SEG_HEX_F = 7'b0001110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Result of decoding one segment pattern.
  typedef struct packed {
    logic       hit;
    logic       blank;
    logic [3:0] nibble;
  } seg_dec_t;

  // Capture FSM states.
  typedef enum logic [1:0] {
    S_WAIT  = 2'd0,
    S_COUNT = 2'd1,
    S_HOLD  = 2'd2
  } cap_state_t;

endpackage

// File: rtl/seg7_to_hex.sv
// Combinational decoder: 7-bit active-low segment pattern to
// {hit, blank, nibble}. Anything not in the code set and not blank is a miss.
module seg7_to_hex
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output seg_dec_t   dec
);

  // Table lookup; defaults describe a miss with nibble 0.
  always_comb begin
    dec = '0;
    case (seg)
      SEG_HEX_0: dec = '{hit: 1'b1, blank: 1'b0, nibble: 4'h0};
      SEG_HEX_1: dec = '{hit: 1'b1, blank: 1'b0, nibble: 4'h1};
      SEG_HEX_2: dec = '{hit: 1'b1, blank: 1'b0, nibble: 4'h2};
      SEG_HEX_3: dec = '{hit: 1'b1, blank: 1'b0, nibble: 4'h3};
      SEG_HEX_4: dec = '{hit: 1'b1, blank: 1'b0, nibble: 4'h4};
      SEG_HEX_5: dec = '{hit: 1'b1, blank: 1'b0, nibble: 4'h5};
      SEG_HEX_6: dec = '{hit: 1'b1, blank: 1'b0, nibble: 4'h6};
      SEG_HEX_7: dec = '{hit: 1'b1, blank: 1'b0, nibble: 4'h7};
      SEG_HEX_8: dec = '{hit: 1'b1, blank: 1'b0, nibble: 4'h8};
      SEG_HEX_9: dec = '{hit: 1'b1, blank: 1'b0, nibble: 4'h9};
      SEG_HEX_A: dec = '{hit: 1'b1, blank: 1'b0, nibble: 4'hA};
      SEG_HEX_B: dec = '{hit: 1'b1, blank: 1'b0, nibble: 4'hB};
      SEG_HEX_C: dec = '{hit: 1'b1, blank: 1'b0, nibble: 4'hC};
      SEG_HEX_D: dec = '{hit: 1'b1, blank: 1'b0, nibble: 4'hD};
      SEG_HEX_E: dec = '{hit: 1'b1, blank: 1'b0, nibble: 4'hE};
      SEG_HEX_F: dec = '{hit: 1'b1, blank: 1'b0, nibble: 4'hF};
      SEG_BLANK: dec = '{hit: 1'b0, blank: 1'b1, nibble: 4'h0};
      default:   dec = '0;
    endcase
  end

endmodule

// File: rtl/seg7_capture.sv
// Watches a multiplexed active-low 7-segment bus and recovers the hex value
// shown on each digit once its pattern has been stable for STABLE_CYCLES
// registered samples. The FSM state is exported on dbg_state for checkers.
module seg7_capture
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [6:0]              seg,
  input  logic [NUM_DIGITS-1:0]   dig_en,
  input  logic                    err_clr,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic                    upd,
  output logic [2:0]              upd_idx,
  output logic                    err,
  output cap_state_t              dbg_state
);

  localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES);

  logic [6:0]            seg_q, seg_p;
  logic [NUM_DIGITS-1:0] en_q, en_p;
  cap_state_t            state, state_n;
  logic [7:0]            cnt, cnt_n;
  logic                  same, onehot, cap;
  logic [2:0]            idx;
  seg_dec_t              dec;

  assign same      = (seg_q == seg_p) && (en_q == en_p);
  assign onehot    = $onehot(en_q);
  assign dbg_state = state;

  seg7_to_hex u_dec (
    .seg (seg_q),
    .dec (dec)
  );

  // Index of the selected digit; only meaningful when en_q is one-hot.
  always_comb begin
    idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (en_q[i]) idx = 3'(i);
    end
  end

  // Input sample register plus a one-cycle-old copy for change detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      seg_q <= SEG_BLANK;
      en_q  <= '0;
      seg_p <= SEG_BLANK;
      en_p  <= '0;
    end else begin
      seg_q <= seg;
      en_q  <= dig_en;
      seg_p <= seg_q;
      en_p  <= en_q;
    end
  end

  // Next state / stability counter. The counter saturates at CNT_MAX in
  // S_HOLD, so a long-held pattern captures exactly once.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    cap     = 1'b0;
    case (state)
      S_WAIT: begin
        if (onehot) begin
          state_n = S_COUNT;
          cnt_n   = 8'd1;
        end else begin
          cnt_n = 8'd0;
        end
      end
      S_COUNT, S_HOLD: begin
        if (!same) begin
          if (onehot) begin
            state_n = S_COUNT;
            cnt_n   = 8'd1;
          end else begin
            state_n = S_WAIT;
            cnt_n   = 8'd0;
          end
        end else if (state == S_COUNT) begin
          if (cnt == CNT_MAX - 8'd1) begin
            cap     = 1'b1;
            state_n = S_HOLD;
            cnt_n   = CNT_MAX;
          end else begin
            cnt_n = cnt + 8'd1;
          end
        end
      end
      default: begin
        state_n = S_WAIT;
        cnt_n   = 8'd0;
      end
    endcase
  end

  // FSM state and counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_WAIT;
      cnt   <= 8'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Capture: update only the selected digit; a miss also raises sticky err,
  // which wins over a simultaneous err_clr.
  always_ff @(posedge clk) begin
    if (reset) begin
      digits      <= '0;
      digit_valid <= '0;
      upd         <= 1'b0;
      upd_idx     <= 3'd0;
      err         <= 1'b0;
    end else begin
      upd     <= 1'b0;
      upd_idx <= 3'd0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (cap && en_q[i]) begin
          if (dec.hit) begin
            digits[4*i +: 4] <= dec.nibble;
            digit_valid[i]   <= 1'b1;
          end else begin
            digit_valid[i]   <= 1'b0;
          end
        end
      end
      if (cap && dec.hit) begin
        upd     <= 1'b1;
        upd_idx <= idx;
      end
      if (cap && !dec.hit && !dec.blank) begin
        err <= 1'b1;
      end else if (err_clr) begin
        err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seg7_capture.sv
// Bench for seg7_capture: a run-length model of the sampled bus predicts all
// outputs every cycle; directed scenarios add literal checks on top.
module tb_seg7_capture;
  import seg7_pkg::*;

  localparam int ND = 4;
  localparam int SC = 4;

  // Independent copy of the display code set, index = hex value.
  localparam logic [6:0] CODE [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };
  localparam logic [6:0] BLANK = 7'b1111111;
  localparam logic [6:0] JUNK  = 7'b1010101;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [6:0]      seg = 7'h7F;
  logic [ND-1:0]   dig_en = '0;
  logic            err_clr = 1'b0;
  logic [4*ND-1:0] digits;
  logic [ND-1:0]   digit_valid;
  logic            upd;
  logic [2:0]      upd_idx;
  logic            err;
  cap_state_t      dbg_state;

  seg7_capture #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
    .clk         (clk),
    .reset       (reset),
    .seg         (seg),
    .dig_en      (dig_en),
    .err_clr     (err_clr),
    .digits      (digits),
    .digit_valid (digit_valid),
    .upd         (upd),
    .upd_idx     (upd_idx),
    .err         (err),
    .dbg_state   (dbg_state)
  );

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // model state
  int            m_nib [ND];
  bit            m_val [ND];
  bit            m_upd;
  int            m_idx;
  bit            m_err;
  logic [6:0]    p_seg;
  logic [ND-1:0] p_en;
  int            run_len = 0;
  bit            chk_on = 1'b0;
  int            cyc = 0;
  int            md, mv;
  int            upd_cnt = 0;
  int            upd_cyc = 0;

  function automatic int onehot_idx(input logic [ND-1:0] e);
    int n = 0;
    int k = -1;
    for (int i = 0; i < ND; i++) begin
      if (e[i] === 1'b1) begin
        n++;
        k = i;
      end
    end
    return (n == 1) ? k : -1;
  endfunction

  function automatic int lookup(input logic [6:0] s);
    for (int i = 0; i < 16; i++) begin
      if (CODE[i] === s) return i;
    end
    return -1;
  endfunction

  function automatic logic [4*ND-1:0] exp_digits();
    logic [4*ND-1:0] r = '0;
    for (int i = 0; i < ND; i++) r[4*i +: 4] = 4'(m_nib[i]);
    return r;
  endfunction

  function automatic logic [ND-1:0] exp_valid();
    logic [ND-1:0] r = '0;
    for (int i = 0; i < ND; i++) r[i] = m_val[i];
    return r;
  endfunction

  // Model: a sample run of exactly SC identical one-hot samples decides the
  // outputs at the following edge.
  always @(posedge clk) begin
    cyc++;
    m_upd = 1'b0;
    m_idx = 0;
    if (reset) begin
      for (int i = 0; i < ND; i++) begin
        m_nib[i] = 0;
        m_val[i] = 1'b0;
      end
      m_err   = 1'b0;
      run_len = 0;
      chk_on  = 1'b1;
    end else begin
      md = onehot_idx(p_en);
      mv = -1;
      if (run_len == SC && md >= 0) begin
        mv = lookup(p_seg);
        if (mv >= 0) begin
          m_nib[md] = mv;
          m_val[md] = 1'b1;
          m_upd     = 1'b1;
          m_idx     = md;
        end else begin
          m_val[md] = 1'b0;
        end
      end
      if (run_len == SC && md >= 0 && mv < 0 && p_seg !== BLANK) m_err = 1'b1;
      else if (err_clr) m_err = 1'b0;
      if (run_len > 0 && seg === p_seg && dig_en === p_en) run_len++;
      else run_len = 1;
      p_seg = seg;
      p_en  = dig_en;
    end
  end

  // Scoreboard compare on the falling edge, every cycle once reset is seen.
  always @(negedge clk) begin
    if (chk_on) begin
      check("digits", 32'(digits), 32'(exp_digits()));
      check("digit_valid", 32'(digit_valid), 32'(exp_valid()));
      check("upd", 32'(upd), 32'(m_upd));
      check("upd_idx", 32'(upd_idx), 32'(m_idx));
      check("err", 32'(err), 32'(m_err));
      if (upd === 1'b1) begin
        upd_cnt++;
        upd_cyc = cyc;
      end
    end
  end

  // driver: called on a falling edge, holds the pattern for n rising edges
  task automatic drive(input logic [6:0] s, input logic [ND-1:0] e, input int n);
    seg    = s;
    dig_en = e;
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  int start;

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_digits", 32'(digits), 32'h0);
    check("reset_valid", 32'(digit_valid), 32'h0);
    check("reset_upd", 32'(upd), 32'h0);
    check("reset_upd_idx", 32'(upd_idx), 32'h0);
    check("reset_err", 32'(err), 32'h0);
    reset = 1'b0;

    // single digit, latency
    upd_cnt = 0;
    start = cyc + 1;
    drive(CODE[3], 4'b0001, 6);
    check("t1_upd_count", 32'(upd_cnt), 32'd1);
    check("t1_latency_edges", 32'(upd_cyc - start + 1), 32'd5);
    check("t1_digit0", 32'(digits[3:0]), 32'h3);
    check("t1_valid", 32'(digit_valid), 32'b0001);

    // four-digit scan
    upd_cnt = 0;
    drive(CODE[2], 4'b0001, 4);
    drive(CODE[10], 4'b0010, 4);
    drive(CODE[13], 4'b0100, 4);
    drive(CODE[7], 4'b1000, 4);
    drive(BLANK, 4'b0000, 2);
    check("t2_digits", 32'(digits), 32'h7DA2);
    check("t2_valid", 32'(digit_valid), 32'b1111);
    check("t2_upd_count", 32'(upd_cnt), 32'd4);

    // too short a hold
    upd_cnt = 0;
    drive(CODE[5], 4'b0001, 3);
    drive(BLANK, 4'b0000, 3);
    check("t3_upd_count", 32'(upd_cnt), 32'd0);
    check("t3_digits", 32'(digits), 32'h7DA2);
    check("t3_valid", 32'(digit_valid), 32'b1111);

    // blank invalidates without changing the nibble
    drive(CODE[5], 4'b0010, 5);
    check("t4_digit1", 32'(digits[7:4]), 32'h5);
    drive(BLANK, 4'b0010, 5);
    check("t4_valid", 32'(digit_valid), 32'b1101);
    check("t4_digit1_kept", 32'(digits[7:4]), 32'h5);
    check("t4_err", 32'(err), 32'h0);

    // miss, sticky err, clear, clear-vs-miss
    drive(JUNK, 4'b0100, 5);
    check("t5_err_set", 32'(err), 32'h1);
    check("t5_valid", 32'(digit_valid), 32'b1001);
    drive(BLANK, 4'b0000, 3);
    check("t5_err_sticky", 32'(err), 32'h1);
    err_clr = 1'b1;
    drive(BLANK, 4'b0000, 1);
    err_clr = 1'b0;
    check("t5_err_clr", 32'(err), 32'h0);
    drive(JUNK, 4'b0100, 4);
    check("t5_err_before", 32'(err), 32'h0);
    err_clr = 1'b1;
    drive(JUNK, 4'b0100, 1);
    err_clr = 1'b0;
    check("t5_err_clr_vs_miss", 32'(err), 32'h1);
    drive(BLANK, 4'b0000, 2);
    err_clr = 1'b1;
    drive(BLANK, 4'b0000, 1);
    err_clr = 1'b0;

    // multi-hot enable never captures
    upd_cnt = 0;
    drive(CODE[8], 4'b0011, 10);
    check("t6_upd_count", 32'(upd_cnt), 32'd0);
    check("t6_digits", 32'(digits), 32'h7D52);
    check("t6_valid", 32'(digit_valid), 32'b1001);
    check("t6_err", 32'(err), 32'h0);

    // reset mid-count, then a fresh count from the first post-reset sample
    upd_cnt = 0;
    drive(CODE[8], 4'b1000, 3);
    reset = 1'b1;
    drive(CODE[8], 4'b1000, 2);
    check("t7_upd_count", 32'(upd_cnt), 32'd0);
    check("t7_digits", 32'(digits), 32'h0);
    check("t7_valid", 32'(digit_valid), 32'h0);
    check("t7_err", 32'(err), 32'h0);
    reset = 1'b0;
    start = cyc + 1;
    drive(CODE[8], 4'b1000, 6);
    check("t7_post_upd_count", 32'(upd_cnt), 32'd1);
    check("t7_post_latency", 32'(upd_cyc - start + 1), 32'd5);
    check("t7_post_digits", 32'(digits), 32'h8000);
    check("t7_post_valid", 32'(digit_valid), 32'b1000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg7_capture.md
# seg7_capture

Monitors a time-multiplexed, active-low 7-segment display bus (segment lines plus one-hot digit enables) and recovers the hex value shown on each digit. A pattern is accepted only after it has been stable for a programmable number of cycles. The block sits beside the display driver as a self-check and readback path, feeding per-digit nibbles, valid flags and an update strobe to test logic or a status register.

## Interface
- `NUM_DIGITS`, 4: number of multiplexed digits (1–8).
- `STABLE_CYCLES`, 4: consecutive identical samples required before capture (2–255).
- `clk`  in  1  system clock; all logic is rising-edge.
- `reset`  in  1  synchronous, active-high reset.
- `seg`  in  7  active-low segment lines; bit 0 = top (a), clockwise through bit 5 (f), bit 6 = middle (g).
- `dig_en`  in  NUM_DIGITS  active-high digit select; must be one-hot to be captured.
- `digits`  out  4*NUM_DIGITS  recovered nibble per digit; digit i occupies bits [4i+3:4i].
- `digit_valid`  out  NUM_DIGITS  bit i = digits[i] holds a decoded value.
- `upd`  out  1  one-cycle pulse on each successful decode.
- `upd_idx`  out  3  index of the digit written when `upd`=1; 0 otherwise.
- `err`  out  1  sticky flag: a stable, non-blank, unrecognised pattern was seen.
- `err_clr`  in  1  clears `err`.

## Operation
- Inputs are registered once into `seg_q`/`en_q`. All decisions use the registered values.
- Code set (active-low, g..a):
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000
  - 4 = 0011001, 5 = 0010010, 6 = 0000010, 7 = 1111000
  - 8 = 0000000, 9 = 0011000, A = 0001000, b = 0000011
  - C = 1000110, d = 0100001, E = 0000110, F = 0001110
  - Blank = 1111111.
- FSM states:
  - **S_WAIT**: `en_q` is not one-hot (zero or multi-hot). The stability counter is held at 0. Moves to S_COUNT when `en_q` becomes one-hot.
  - **S_COUNT**: The counter increments while `{seg_q,en_q}` equals its previous value. Any change restarts the count at 1, or returns to S_WAIT if `en_q` is no longer one-hot. When the count reaches STABLE_CYCLES, the block captures and moves to S_HOLD.
  - **S_HOLD**: No further captures. Leaves on any change of `{seg_q,en_q}`, to S_COUNT (count 1) or to S_WAIT.
- Capture action for digit i (the index of the set bit in `en_q`):
  - Table hit: write `digits[i]`, set `digit_valid[i]`, pulse `upd` with `upd_idx`=i.
  - Blank: clear `digit_valid[i]`; `digits[i]` is unchanged; no `upd`, no `err`.
  - Miss: clear `digit_valid[i]`; `digits[i]` is unchanged; set `err`; no `upd`.
- Other digits are never touched by a capture.
- `err_clr` and a new miss in the same cycle: `err` ends at 1.

## Timing
- Reset values: `digits`=0, `digit_valid`=0, `upd`=0, `upd_idx`=0, `err`=0, `seg_q`=7'h7F, `en_q`=0, state S_WAIT, counter 0.
- A pattern first present at input edge k and unchanged through edge k+STABLE_CYCLES−1 produces registered outputs (`upd`, `digits`, `digit_valid`, `err`) valid after edge k+STABLE_CYCLES.
  - Latency is STABLE_CYCLES+1 edges from the first sample to visible outputs.
- `upd` is high for exactly one cycle per stable period.
- A pattern held for fewer than STABLE_CYCLES samples is ignored.
- The counter saturates in S_HOLD and does not wrap.
- Reset asserted mid-count abandons the capture. The first count after reset release starts at the first post-reset sample.

## Structure
- Package `seg7_pkg` holds the 16 segment-code constants, `SEG_BLANK`, and the segment bit-order definition. Both display encoding and this block use it.
- Sub-module `seg7_to_hex` is combinational: maps the 7-bit pattern to `{hit, blank, nibble[3:0]}`.
- The FSM, counter and digit registers live in `seg7_capture`.

## Test plan
- Reset, then `dig_en`=0001, `seg`=0110000 held 6 cycles → `upd`=1 once, `upd_idx`=0, `digits[3:0]`=3, `digit_valid`=0001, with output latency 5 edges.
- Scan 4 digits, each held 4 cycles, with 2, A, d, 7 → `digits`=16'h7DA2, `digit_valid`=1111, four `upd` pulses.
- Pattern held 3 cycles then changed (STABLE_CYCLES=4) → no `upd`; all outputs unchanged.
- `dig_en`=0010, `seg`=1111111 after digit 1 held 5 → `digit_valid[1]`=0, `digits[7:4]` still 5, `err`=0.
- `seg`=1010101 stable on digit 2 → `err`=1 and stays 1. Assert `err_clr` alone → `err`=0. Assert `err_clr` together with a new miss → `err`=1.
- `dig_en`=0011 stable 10 cycles → no capture. Assert `reset` at count 3 of a valid pattern → all outputs 0, no `upd`.
